pipe_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage RV32I pipeline (fetch, decode, alu, mem, writeback).
- Drives the STALL/FLUSH inputs of the fetch, decode and alu stage latches.
- Detects load-use hazards between the decode and alu stages.
- Sequences PC redirection on taken jumps/branches.
- Freezes the pipeline while the memory interface is busy, holding back any redirect that arrives during the freeze.

---
 rtl/pipe_hazard_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline: load-use bubbles, PC redirects, memory freeze.
// Optional perf counters enabled by defining PIPE_HAZARD_CTRL_PERF_EN.
module pipe_hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        D_VALID,
    input  logic [4:0]  D_REG_S1,
    input  logic [4:0]  D_REG_S2,
    input  logic        D_USE_S2,
    input  logic        A_VALID,
    input  logic        A_IS_LOAD,
    input  logic [4:0]  A_REG_D,
    input  logic        A_DO_JMP,
    input  logic [31:0] A_NEW_PC,
    input  logic        MEM_BUSY,
    output logic        STALL_F,
    output logic        STALL_D,
    output logic        STALL_A,
    output logic        FLUSH_D,
    output logic        FLUSH_A,
    output logic        PC_WE,
    output logic [31:0] PC_NEW,
    output logic        BUSY
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    ,
    output logic [31:0] PERF_STALL_CNT,
    output logic [31:0] PERF_FLUSH_CNT,
    output logic [31:0] PERF_LU_CNT
`endif
);

    localparam int unsigned CNT_W = 3;
    localparam int unsigned PC_W  = 32;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pend_jmp_q, pend_jmp_d;
    logic [PC_W-1:0]    pend_pc_q, pend_pc_d;

    logic               jmp_c;
    logic               hazard_c;
    logic               redir_c;
    logic [PC_W-1:0]    redir_pc_c;
    logic               lu_c;

    assign jmp_c    = A_VALID & A_DO_JMP;
    assign hazard_c = A_VALID & A_IS_LOAD & (A_REG_D != 5'd0) & D_VALID &
                      ((D_REG_S1 == A_REG_D) | (D_USE_S2 & (D_REG_S2 == A_REG_D)));

    // Next-state and output decode; outputs are forced low while reset is held.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pend_jmp_d = pend_jmp_q;
        pend_pc_d  = pend_pc_q;
        STALL_F    = 1'b0;
        STALL_D    = 1'b0;
        STALL_A    = 1'b0;
        FLUSH_D    = 1'b0;
        FLUSH_A    = 1'b0;
        PC_WE      = 1'b0;
        PC_NEW     = '0;
        BUSY       = 1'b0;
        redir_c    = 1'b0;
        redir_pc_c = '0;
        lu_c       = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (MEM_BUSY) begin
                    STALL_F = 1'b1;
                    STALL_D = 1'b1;
                    STALL_A = 1'b1;
                    state_d = ST_MEM_WAIT;
                    if (jmp_c) begin
                        pend_jmp_d = 1'b1;
                        pend_pc_d  = A_NEW_PC;
                    end
                end else if (jmp_c) begin
                    redir_c    = 1'b1;
                    redir_pc_c = A_NEW_PC;
                end else if (hazard_c) begin
                    STALL_F = 1'b1;
                    STALL_D = 1'b1;
                    FLUSH_A = 1'b1;
                    lu_c    = 1'b1;
                end
            end
            ST_FLUSH: begin
                BUSY    = 1'b1;
                FLUSH_D = 1'b1;
                if (MEM_BUSY) begin
                    STALL_F = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_MEM_WAIT: begin
                BUSY = 1'b1;
                if (MEM_BUSY) begin
                    STALL_F = 1'b1;
                    STALL_D = 1'b1;
                    STALL_A = 1'b1;
                end else if (pend_jmp_q) begin
                    redir_c    = 1'b1;
                    redir_pc_c = pend_pc_q;
                    pend_jmp_d = 1'b0;
                    pend_pc_d  = '0;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        // The redirect response is shared by a live jump in RUN and a held jump leaving MEM_WAIT.
        if (redir_c) begin
            PC_WE   = 1'b1;
            PC_NEW  = redir_pc_c;
            FLUSH_D = 1'b1;
            FLUSH_A = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
                state_d = ST_FLUSH;
            end else begin
                state_d = ST_RUN;
            end
        end

        if (!RST) begin
            STALL_F = 1'b0;
            STALL_D = 1'b0;
            STALL_A = 1'b0;
            FLUSH_D = 1'b0;
            FLUSH_A = 1'b0;
            PC_WE   = 1'b0;
            PC_NEW  = '0;
            BUSY    = 1'b0;
            lu_c    = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= ST_RUN;
            cnt_q      <= '0;
            pend_jmp_q <= 1'b0;
            pend_pc_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pend_jmp_q <= pend_jmp_d;
            pend_pc_q  <= pend_pc_d;
        end
    end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [31:0] perf_stall_q, perf_flush_q, perf_lu_q;

    // Event counters; natural 32-bit wrap.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
            perf_lu_q    <= '0;
        end else begin
            if (STALL_F) perf_stall_q <= perf_stall_q + 32'd1;
            if (PC_WE)   perf_flush_q <= perf_flush_q + 32'd1;
            if (lu_c)    perf_lu_q    <= perf_lu_q + 32'd1;
        end
    end

    assign PERF_STALL_CNT = perf_stall_q;
    assign PERF_FLUSH_CNT = perf_flush_q;
    assign PERF_LU_CNT    = perf_lu_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a cycle-level reference model checked every negedge.
module tb_pipe_hazard_ctrl;

    localparam int unsigned FC = 2;

    logic        CLK = 1'b0;
    logic        RST;
    logic        D_VALID, D_USE_S2, A_VALID, A_IS_LOAD, A_DO_JMP, MEM_BUSY;
    logic [4:0]  D_REG_S1, D_REG_S2, A_REG_D;
    logic [31:0] A_NEW_PC;
    logic        STALL_F, STALL_D, STALL_A, FLUSH_D, FLUSH_A, PC_WE, BUSY;
    logic [31:0] PC_NEW;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [31:0] PERF_STALL_CNT, PERF_FLUSH_CNT, PERF_LU_CNT;
    logic [31:0] m_perf_stall = 0, m_perf_flush = 0, m_perf_lu = 0;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    pipe_hazard_ctrl #(.FLUSH_CYCLES(FC)) dut (
        .CLK(CLK), .RST(RST),
        .D_VALID(D_VALID), .D_REG_S1(D_REG_S1), .D_REG_S2(D_REG_S2), .D_USE_S2(D_USE_S2),
        .A_VALID(A_VALID), .A_IS_LOAD(A_IS_LOAD), .A_REG_D(A_REG_D),
        .A_DO_JMP(A_DO_JMP), .A_NEW_PC(A_NEW_PC), .MEM_BUSY(MEM_BUSY),
        .STALL_F(STALL_F), .STALL_D(STALL_D), .STALL_A(STALL_A),
        .FLUSH_D(FLUSH_D), .FLUSH_A(FLUSH_A), .PC_WE(PC_WE), .PC_NEW(PC_NEW), .BUSY(BUSY)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        ,
        .PERF_STALL_CNT(PERF_STALL_CNT), .PERF_FLUSH_CNT(PERF_FLUSH_CNT), .PERF_LU_CNT(PERF_LU_CNT)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frozen = waiting on memory, flush_left = flush cycles still owed after this one.
    bit          m_frozen;
    int          m_flush_left;
    bit          m_pend;
    logic [31:0] m_pend_pc;

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            m_frozen     <= 1'b0;
            m_flush_left <= 0;
            m_pend       <= 1'b0;
            m_pend_pc    <= 32'h0;
        end else if (m_frozen) begin
            if (!MEM_BUSY) begin
                m_frozen <= 1'b0;
                if (m_pend) begin
                    m_flush_left <= FC - 1;
                    m_pend       <= 1'b0;
                end
            end
        end else if (m_flush_left > 0) begin
            if (!MEM_BUSY) m_flush_left <= m_flush_left - 1;
        end else if (MEM_BUSY) begin
            m_frozen <= 1'b1;
            if (A_VALID && A_DO_JMP) begin
                m_pend    <= 1'b1;
                m_pend_pc <= A_NEW_PC;
            end
        end else if (A_VALID && A_DO_JMP) begin
            m_flush_left <= FC - 1;
        end
    end

    // Compare every output against the model on each falling edge.
    always @(negedge CLK) begin
        automatic logic e_sf = 0, e_sd = 0, e_sa = 0, e_fd = 0, e_fa = 0, e_we = 0, e_busy = 0, e_lu = 0;
        automatic logic [31:0] e_pc = 0;
        automatic bit hz = A_VALID && A_IS_LOAD && (A_REG_D != 0) && D_VALID &&
                           ((D_REG_S1 == A_REG_D) || (D_USE_S2 && (D_REG_S2 == A_REG_D)));
        if (RST) begin
            if (m_frozen) begin
                e_busy = 1;
                if (MEM_BUSY) begin e_sf = 1; e_sd = 1; e_sa = 1; end
                else if (m_pend) begin e_we = 1; e_pc = m_pend_pc; e_fd = 1; e_fa = 1; end
            end else if (m_flush_left > 0) begin
                e_busy = 1; e_fd = 1;
                if (MEM_BUSY) e_sf = 1;
            end else if (MEM_BUSY) begin
                e_sf = 1; e_sd = 1; e_sa = 1;
            end else if (A_VALID && A_DO_JMP) begin
                e_we = 1; e_pc = A_NEW_PC; e_fd = 1; e_fa = 1;
            end else if (hz) begin
                e_sf = 1; e_sd = 1; e_fa = 1; e_lu = 1;
            end
        end
        chk("STALL_F", 32'(STALL_F), 32'(e_sf));
        chk("STALL_D", 32'(STALL_D), 32'(e_sd));
        chk("STALL_A", 32'(STALL_A), 32'(e_sa));
        chk("FLUSH_D", 32'(FLUSH_D), 32'(e_fd));
        chk("FLUSH_A", 32'(FLUSH_A), 32'(e_fa));
        chk("PC_WE",   32'(PC_WE),   32'(e_we));
        chk("PC_NEW",  PC_NEW,       e_pc);
        chk("BUSY",    32'(BUSY),    32'(e_busy));
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        if (!RST) begin
            m_perf_stall = 0; m_perf_flush = 0; m_perf_lu = 0;
        end
        chk("PERF_STALL_CNT", PERF_STALL_CNT, m_perf_stall);
        chk("PERF_FLUSH_CNT", PERF_FLUSH_CNT, m_perf_flush);
        chk("PERF_LU_CNT",    PERF_LU_CNT,    m_perf_lu);
        m_perf_stall = m_perf_stall + 32'(e_sf);
        m_perf_flush = m_perf_flush + 32'(e_we);
        m_perf_lu    = m_perf_lu + 32'(e_lu);
`endif
    end

    task automatic idle();
        D_VALID = 0; D_REG_S1 = 0; D_REG_S2 = 0; D_USE_S2 = 0;
        A_VALID = 0; A_IS_LOAD = 0; A_REG_D = 0; A_DO_JMP = 0; A_NEW_PC = 0;
        MEM_BUSY = 0;
    endtask

    task automatic adv();
        @(posedge CLK);
        #1;
    endtask

    task automatic jump(input logic [31:0] pc);
        A_VALID = 1; A_DO_JMP = 1; A_NEW_PC = pc;
    endtask

    initial begin
        idle();
        RST = 0;
        MEM_BUSY = 1;
        @(negedge CLK);
        chk("lit_rst_stall_f", 32'(STALL_F), 0);
        chk("lit_rst_busy",    32'(BUSY),    0);
        adv();
        MEM_BUSY = 0;
        RST = 1;
        adv();

        // Load-use on rs1
        A_VALID = 1; A_IS_LOAD = 1; A_REG_D = 5; D_VALID = 1; D_REG_S1 = 5;
        @(negedge CLK);
        chk("lit_lu_stall_f", 32'(STALL_F), 1);
        chk("lit_lu_stall_d", 32'(STALL_D), 1);
        chk("lit_lu_flush_a", 32'(FLUSH_A), 1);
        chk("lit_lu_stall_a", 32'(STALL_A), 0);
        adv();
        A_VALID = 0; A_IS_LOAD = 0;
        @(negedge CLK);
        chk("lit_lu_clear", 32'(STALL_D), 0);
        adv();

        // x0 destination never hazards
        A_VALID = 1; A_IS_LOAD = 1; A_REG_D = 0; D_REG_S1 = 0;
        @(negedge CLK);
        chk("lit_lu_x0", 32'(STALL_F), 0);
        adv();

        // rs2 gated by D_USE_S2
        D_REG_S1 = 3; D_REG_S2 = 7; A_REG_D = 7; D_USE_S2 = 0;
        @(negedge CLK);
        chk("lit_rs2_unused", 32'(STALL_D), 0);
        adv();
        D_USE_S2 = 1;
        @(negedge CLK);
        chk("lit_rs2_used", 32'(STALL_D), 1);
        adv();
        idle();
        adv();

        // Redirect with a two-cycle flush
        jump(32'h0000_0100);
        @(negedge CLK);
        chk("lit_jmp_pc_we",  32'(PC_WE), 1);
        chk("lit_jmp_pc_new", PC_NEW, 32'h0000_0100);
        chk("lit_jmp_flush_a", 32'(FLUSH_A), 1);
        adv();
        idle();
        @(negedge CLK);
        chk("lit_flush1_fd",   32'(FLUSH_D), 1);
        chk("lit_flush1_busy", 32'(BUSY), 1);
        chk("lit_flush1_fa",   32'(FLUSH_A), 0);
        adv();
        @(negedge CLK);
        chk("lit_flush2_fd",   32'(FLUSH_D), 0);
        chk("lit_flush2_busy", 32'(BUSY), 0);
        adv();

        // Jump captured on first of three busy cycles
        MEM_BUSY = 1; jump(32'h0000_0200);
        @(negedge CLK);
        chk("lit_mw0_stall_a", 32'(STALL_A), 1);
        adv();
        A_NEW_PC = 32'h0000_0300;
        adv();
        adv();
        MEM_BUSY = 0;
        @(negedge CLK);
        chk("lit_mw_pc_we",  32'(PC_WE), 1);
        chk("lit_mw_pc_new", PC_NEW, 32'h0000_0200);
        chk("lit_mw_stall_a", 32'(STALL_A), 0);
        adv();
        idle();
        @(negedge CLK);
        chk("lit_mw_flush_d", 32'(FLUSH_D), 1);
        adv();
        adv();

        // Jump beats load-use in the same cycle
        jump(32'h0000_0400);
        A_IS_LOAD = 1; A_REG_D = 9; D_VALID = 1; D_REG_S1 = 9;
        @(negedge CLK);
        chk("lit_prio_pc_we",   32'(PC_WE), 1);
        chk("lit_prio_stall_d", 32'(STALL_D), 0);
        adv();
        idle();
        adv();
        adv();

        // Memory busy in FLUSH freezes the flush countdown
        jump(32'h0000_0500);
        adv();
        idle();
        MEM_BUSY = 1;
        @(negedge CLK);
        chk("lit_fbusy_stall_f", 32'(STALL_F), 1);
        chk("lit_fbusy_stall_d", 32'(STALL_D), 0);
        adv();
        adv();
        MEM_BUSY = 0;
        @(negedge CLK);
        chk("lit_fbusy_still_fd", 32'(FLUSH_D), 1);
        adv();
        adv();

        // Reset asserted in the middle of FLUSH
        jump(32'h0000_0600);
        adv();
        idle();
        #2;
        RST = 0;
        #1;
        chk("lit_rstmid_fd",   32'(FLUSH_D), 0);
        chk("lit_rstmid_busy", 32'(BUSY), 0);
        adv();
        RST = 1;
        @(negedge CLK);
        chk("lit_rstpost_fd", 32'(FLUSH_D), 0);
        adv();

        // Mixed traffic checked by the model only
        for (int i = 0; i < 80; i++) begin
            D_VALID   = 1'($urandom_range(0, 1));
            D_REG_S1  = 5'($urandom_range(0, 3));
            D_REG_S2  = 5'($urandom_range(0, 3));
            D_USE_S2  = 1'($urandom_range(0, 1));
            A_VALID   = 1'($urandom_range(0, 1));
            A_IS_LOAD = 1'($urandom_range(0, 1));
            A_REG_D   = 5'($urandom_range(0, 3));
            A_DO_JMP  = ($urandom_range(0, 4) == 0);
            A_NEW_PC  = $urandom;
            MEM_BUSY  = ($urandom_range(0, 3) == 0);
            adv();
        end
        idle();
        repeat (4) adv();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
